// File: rtl/chunked_serial_adder_if.sv
// Valid/ready handshake bundle for chunked_serial_adder; the sub signal exists
// only when CHUNKED_SERIAL_ADDER_SUB_EN is defined.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle ripple-carry adder reusing a CHUNK-bit full-adder chain over WIDTH/CHUNK cycles.
// Optional subtract mode is enabled by defining CHUNKED_SERIAL_ADDER_SUB_EN.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  chunked_serial_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [CHUNK+1:0] add_s;
  logic [CHUNK-1:0] chunk_sum_s;
  logic             chunk_cout_s;
  logic             msb_cin_s;
  logic [WIDTH-1:0] b_in_s;
  logic             carry_in_s;

  // Returns {carry into top bit, carry out, sum bits} of one full-adder chain.
  function automatic logic [CHUNK+1:0] add_chunk(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             c_in
  );
    logic [CHUNK-1:0] s;
    logic             c;
    logic             c_top;
    s     = {CHUNK{1'b0}};
    c     = c_in;
    c_top = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      c_top = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return {c_top, c, s};
  endfunction

  assign add_s        = add_chunk(a_r[CHUNK-1:0], b_r[CHUNK-1:0], carry_r);
  assign chunk_sum_s  = add_s[CHUNK-1:0];
  assign chunk_cout_s = add_s[CHUNK];
  assign msb_cin_s    = add_s[CHUNK+1];

`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so the latched carry replaces cin.
  assign b_in_s     = bus.sub ? ~bus.b : bus.b;
  assign carry_in_s = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_in_s     = bus.b;
  assign carry_in_s = bus.cin;
`endif

  // Control FSM and chunk datapath; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_r        <= bus.a;
            b_r        <= b_in_s;
            carry_r    <= carry_in_s;
            cnt_r      <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= RUN;
          end
        end
        RUN: begin
          sum_r[cnt_r*CHUNK +: CHUNK] <= chunk_sum_s;
          a_r     <= a_r >> CHUNK;
          b_r     <= b_r >> CHUNK;
          carry_r <= chunk_cout_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_K) begin
            cout_r      <= chunk_cout_s;
            ovf_r       <= msb_cin_s ^ chunk_cout_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          // in_ready rises on this edge, so the next accept is one cycle later.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder: arithmetic model plus directed vectors
// on WIDTH=8 with CHUNK=2 and CHUNK=8 (and CHUNK=4 subtraction under CHUNKED_SERIAL_ADDER_SUB_EN).
module tb_chunked_serial_adder;
  localparam int W  = 8;
  localparam int N2 = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t exp_q[$];

  chunked_serial_adder_if #(.WIDTH(W)) bus_c2();
  chunked_serial_adder_if #(.WIDTH(W)) bus_c8();

  chunked_serial_adder #(.WIDTH(W), .CHUNK(2)) u_c2 (.clk(clk), .rst_n(rst_n), .bus(bus_c2));
  chunked_serial_adder #(.WIDTH(W), .CHUNK(8)) u_c8 (.clk(clk), .rst_n(rst_n), .bus(bus_c8));

`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
  chunked_serial_adder_if #(.WIDTH(W)) bus_c4();
  chunked_serial_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (.clk(clk), .rst_n(rst_n), .bus(bus_c4));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Result of x + y + c (or x - y when sub) as {ovf, cout, sum}, from plain arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic sub);
    logic [W-1:0] yy;
    logic [W:0]   t;
    logic         cc;
    logic         o;
    yy = sub ? ~y : y;
    cc = sub ? 1'b1 : c;
    t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    o  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {o, t[W], t[W-1:0]};
  endfunction

  // Scoreboard feed for the CHUNK=2 instance: push on accept, pop on consume.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus_c2.in_valid && bus_c2.in_ready) begin
        logic [W+1:0] m;
        exp_t e;
        m     = model(bus_c2.a, bus_c2.b, bus_c2.cin, 1'b0);
        e.sum = m[W-1:0];
        e.cout = m[W];
        e.ovf = m[W+1];
        e.acc = cyc;
        exp_q.push_back(e);
      end
      if (bus_c2.out_valid && bus_c2.out_ready && exp_q.size() > 0) exp_q.pop_front();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic compare_step(inout logic ov_prev);
    int elapsed;
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else if (bus_c2.out_valid) begin
      if (exp_q.size() == 0) begin
        check("c2_spurious_out_valid", 32'(bus_c2.out_valid), 32'd0);
      end else begin
        check("c2_sum", 32'(bus_c2.sum), 32'(exp_q[0].sum));
        check("c2_cout", 32'(bus_c2.cout), 32'(exp_q[0].cout));
        check("c2_ovf", 32'(bus_c2.ovf), 32'(exp_q[0].ovf));
        check("c2_in_ready_done", 32'(bus_c2.in_ready), 32'd0);
        check("c2_busy_done", 32'(bus_c2.busy), 32'd1);
        if (!ov_prev) begin
          elapsed = cyc - exp_q[0].acc - 1;
          check("c2_latency", 32'(elapsed), 32'(N2));
        end
      end
      ov_prev = 1'b1;
    end else begin
      if (exp_q.size() != 0) begin
        elapsed = cyc - exp_q[0].acc - 1;
        check("c2_busy_run", 32'(bus_c2.busy), 32'd1);
        check("c2_in_ready_run", 32'(bus_c2.in_ready), 32'd0);
        if (elapsed >= N2) check("c2_out_valid_due", 32'(bus_c2.out_valid), 32'd1);
      end else begin
        check("c2_busy_idle", 32'(bus_c2.busy), 32'd0);
        check("c2_in_ready_idle", 32'(bus_c2.in_ready), 32'd1);
      end
      ov_prev = 1'b0;
    end
  endtask

  task automatic wait_valid_c2();
    int n;
    n = 0;
    while (!bus_c2.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("c2_wait_out_valid", 32'(bus_c2.out_valid), 32'd1);
  endtask

  task automatic consume_c2(input int hold);
    repeat (hold) @(negedge clk);
    bus_c2.out_ready = 1'b1;
    @(negedge clk);
    bus_c2.out_ready = 1'b0;
  endtask

  task automatic op_c2(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input logic [W-1:0] es, input logic ec, input logic eo, input string tag);
    bus_c2.a = x;
    bus_c2.b = y;
    bus_c2.cin = c;
    bus_c2.in_valid = 1'b1;
    @(negedge clk);
    bus_c2.in_valid = 1'b0;
    wait_valid_c2();
    check({tag, "_sum"}, 32'(bus_c2.sum), 32'(es));
    check({tag, "_cout"}, 32'(bus_c2.cout), 32'(ec));
    check({tag, "_ovf"}, 32'(bus_c2.ovf), 32'(eo));
    consume_c2(0);
  endtask

  initial begin
    logic ov_prev;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    ov_prev = 1'b0;
    {bus_c2.in_valid, bus_c2.out_ready, bus_c2.cin} = 3'b000;
    {bus_c8.in_valid, bus_c8.out_ready, bus_c8.cin} = 3'b000;
    bus_c2.a = 8'h00; bus_c2.b = 8'h00;
    bus_c8.a = 8'h00; bus_c8.b = 8'h00;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    bus_c2.sub = 1'b0;
    bus_c8.sub = 1'b0;
    {bus_c4.in_valid, bus_c4.out_ready, bus_c4.cin, bus_c4.sub} = 4'b0000;
    bus_c4.a = 8'h00; bus_c4.b = 8'h00;
`endif
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus_c2.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus_c2.out_valid), 32'd0);
    check("rst_busy", 32'(bus_c2.busy), 32'd0);
    check("rst_sum", 32'(bus_c2.sum), 32'd0);
    check("rst_cout_ovf", 32'({bus_c2.cout, bus_c2.ovf}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    fork
      forever begin
        @(negedge clk);
        compare_step(ov_prev);
      end
    join_none

    // Model sanity against hand-computed values.
    check("model_ff_01", 32'(model(8'hFF, 8'h01, 1'b0, 1'b0)), 32'h100);
    check("model_7f_01", 32'(model(8'h7F, 8'h01, 1'b0, 1'b0)), 32'h280);
    check("model_05_m07", 32'(model(8'h05, 8'h07, 1'b0, 1'b1)), 32'h0FE);

    op_c2(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "c2_ff_01");
    op_c2(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, "c2_80_80_c1");
    op_c2(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, "c2_5a_33");

    // Backpressure: hold DONE for 5 cycles while a second request is pending.
    bus_c2.a = 8'h7F; bus_c2.b = 8'h01; bus_c2.cin = 1'b0; bus_c2.in_valid = 1'b1;
    @(negedge clk);
    bus_c2.in_valid = 1'b0;
    wait_valid_c2();
    bus_c2.a = 8'h11; bus_c2.b = 8'h22; bus_c2.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(bus_c2.out_valid), 32'd1);
      check("bp_sum", 32'(bus_c2.sum), 32'h80);
      check("bp_cout_ovf", 32'({bus_c2.cout, bus_c2.ovf}), 32'd1);
      check("bp_in_ready", 32'(bus_c2.in_ready), 32'd0);
      @(negedge clk);
    end
    bus_c2.out_ready = 1'b1;
    @(negedge clk);
    bus_c2.out_ready = 1'b0;
    check("bp_release_in_ready", 32'(bus_c2.in_ready), 32'd1);
    check("bp_release_busy", 32'(bus_c2.busy), 32'd0);
    @(negedge clk);
    bus_c2.in_valid = 1'b0;
    check("bp_second_accepted", 32'(bus_c2.busy), 32'd1);
    wait_valid_c2();
    check("bp_second_sum", 32'(bus_c2.sum), 32'h33);
    consume_c2(1);

    // Reset after two RUN cycles discards the partial result.
    bus_c2.a = 8'hAA; bus_c2.b = 8'h55; bus_c2.in_valid = 1'b1;
    @(negedge clk);
    bus_c2.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus_c2.in_ready), 32'd1);
    check("midrst_busy", 32'(bus_c2.busy), 32'd0);
    check("midrst_out_valid", 32'(bus_c2.out_valid), 32'd0);
    check("midrst_sum", 32'(bus_c2.sum), 32'd0);
    check("midrst_cout_ovf", 32'({bus_c2.cout, bus_c2.ovf}), 32'd0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    op_c2(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "c2_after_rst");

    // CHUNK == WIDTH: single RUN cycle.
    bus_c8.a = 8'hA5; bus_c8.b = 8'h5A; bus_c8.cin = 1'b1; bus_c8.in_valid = 1'b1;
    @(negedge clk);
    bus_c8.in_valid = 1'b0;
    check("c8_busy_run", 32'(bus_c8.busy), 32'd1);
    @(negedge clk);
    check("c8_out_valid_1cyc", 32'(bus_c8.out_valid), 32'd1);
    check("c8_a5_5a_sum", 32'(bus_c8.sum), 32'h00);
    check("c8_a5_5a_cout_ovf", 32'({bus_c8.cout, bus_c8.ovf}), 32'h2);
    check("c8_in_ready_done", 32'(bus_c8.in_ready), 32'd0);
    bus_c8.out_ready = 1'b1;
    @(negedge clk);
    bus_c8.out_ready = 1'b0;
    bus_c8.a = 8'h7F; bus_c8.b = 8'h7F; bus_c8.cin = 1'b1; bus_c8.in_valid = 1'b1;
    @(negedge clk);
    bus_c8.in_valid = 1'b0;
    @(negedge clk);
    check("c8_7f_7f_sum", 32'(bus_c8.sum), 32'hFF);
    check("c8_7f_7f_cout_ovf", 32'({bus_c8.cout, bus_c8.ovf}), 32'h1);
    bus_c8.out_ready = 1'b1;
    @(negedge clk);
    bus_c8.out_ready = 1'b0;

`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    // Subtraction on CHUNK=4: two RUN cycles; cin is ignored.
    bus_c4.a = 8'h05; bus_c4.b = 8'h07; bus_c4.sub = 1'b1; bus_c4.cin = 1'b0; bus_c4.in_valid = 1'b1;
    @(negedge clk);
    bus_c4.in_valid = 1'b0;
    @(negedge clk);
    check("c4_not_early", 32'(bus_c4.out_valid), 32'd0);
    @(negedge clk);
    check("c4_sub1_valid", 32'(bus_c4.out_valid), 32'd1);
    check("c4_sub1_sum", 32'(bus_c4.sum), 32'hFE);
    check("c4_sub1_cout_ovf", 32'({bus_c4.cout, bus_c4.ovf}), 32'h0);
    bus_c4.out_ready = 1'b1;
    @(negedge clk);
    bus_c4.out_ready = 1'b0;
    bus_c4.a = 8'h80; bus_c4.b = 8'h01; bus_c4.in_valid = 1'b1;
    @(negedge clk);
    bus_c4.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("c4_sub2_valid", 32'(bus_c4.out_valid), 32'd1);
    check("c4_sub2_sum", 32'(bus_c4.sum), 32'h7F);
    check("c4_sub2_cout_ovf", 32'({bus_c4.cout, bus_c4.ovf}), 32'h3);
    bus_c4.out_ready = 1'b1;
    @(negedge clk);
    bus_c4.out_ready = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
